// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory / writeback-feed stage downstream of the ALU. Non-memory
//               results pass straight to writeback; loads and stores run a
//               request/ack/response bus transaction while stalling the ALU,
//               and alignment, illegal-op and bus-timeout traps are flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int unsigned RESP_TIMEOUT = 256,
  parameter logic [7:0]  TRAP_ALIGN   = 8'h07,
  parameter logic [7:0]  TRAP_ILLEGAL = 8'h02,
  parameter logic [7:0]  TRAP_ACCESS  = 8'h29
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exe_mem,
  input  logic [1:0]  opcode,
  input  logic [5:0]  op3,
  input  logic [4:0]  rd,
  input  logic [63:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_blocked,
  output logic        req,
  output logic [31:0] req_addr,
  output logic        req_we,
  output logic [1:0]  req_size,
  output logic [31:0] req_wdata,
  input  logic        req_ack,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_trap,
  output logic [7:0]  trap_type
);

  localparam int unsigned CNT_W = $clog2(RESP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             req_we_q, req_we_d;
  logic [1:0]       req_size_q, req_size_d;
  logic [31:0]      req_wdata_q, req_wdata_d;
  logic             ld_q, ld_d;
  logic             sgn_q, sgn_d;
  logic [4:0]       rd_q, rd_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             mem_trap_q, mem_trap_d;
  logic [7:0]       trap_type_q, trap_type_d;

  logic             accept;
  logic             dec_legal;
  logic             dec_load;
  logic             dec_sgn;
  logic [1:0]       dec_size;
  logic             dec_misalign;
  logic [31:0]      wdata_rep;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_val;
  logic             unused_addr_hi;

  // Only the low word of the ALU result is meaningful here.
  assign unused_addr_hi = ^addr[63:32];

  assign accept      = exe_mem && ((state_q == S_IDLE) || (state_q == S_WB));
  assign mem_blocked = (state_q == S_REQ) || (state_q == S_WAIT);
  assign req         = (state_q == S_REQ);
  assign req_addr    = req_addr_q;
  assign req_we      = req_we_q;
  assign req_size    = req_size_q;
  assign req_wdata   = req_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign mem_trap    = mem_trap_q;
  assign trap_type   = trap_type_q;

  // Decode op3 of a memory instruction into direction, width and sign, and check alignment.
  always_comb begin
    dec_legal = 1'b1;
    dec_load  = 1'b0;
    dec_sgn   = 1'b0;
    dec_size  = 2'd2;
    case (op3)
      6'h00: begin dec_load = 1'b1; dec_size = 2'd2; end
      6'h01: begin dec_load = 1'b1; dec_size = 2'd0; end
      6'h02: begin dec_load = 1'b1; dec_size = 2'd1; end
      6'h04: begin dec_load = 1'b0; dec_size = 2'd2; end
      6'h05: begin dec_load = 1'b0; dec_size = 2'd0; end
      6'h06: begin dec_load = 1'b0; dec_size = 2'd1; end
      6'h09: begin dec_load = 1'b1; dec_sgn = 1'b1; dec_size = 2'd0; end
      6'h0A: begin dec_load = 1'b1; dec_sgn = 1'b1; dec_size = 2'd1; end
      default: dec_legal = 1'b0;
    endcase
    dec_misalign = ((dec_size == 2'd1) && addr[0]) ||
                   ((dec_size == 2'd2) && (addr[1:0] != 2'b00));
  end

  // Replicate store data across all byte lanes so the bus can pick any lane.
  always_comb begin
    case (dec_size)
      2'd0:    wdata_rep = {4{store_data[7:0]}};
      2'd1:    wdata_rep = {2{store_data[15:0]}};
      default: wdata_rep = store_data;
    endcase
  end

  // Extract and extend the addressed big-endian lane of the response word.
  always_comb begin
    case (req_addr_q[1:0])
      2'd0:    ld_byte = resp_data[31:24];
      2'd1:    ld_byte = resp_data[23:16];
      2'd2:    ld_byte = resp_data[15:8];
      default: ld_byte = resp_data[7:0];
    endcase
    ld_half = req_addr_q[1] ? resp_data[15:0] : resp_data[31:16];
    case (req_size_q)
      2'd0:    ld_val = sgn_q ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
      2'd1:    ld_val = sgn_q ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
      default: ld_val = resp_data;
    endcase
  end

  // Next-state and next-output logic; a new accept overrides the WB exit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_size_d  = req_size_q;
    req_wdata_d = req_wdata_q;
    ld_d        = ld_q;
    sgn_d       = sgn_q;
    rd_d        = rd_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    mem_trap_d  = 1'b0;
    trap_type_d = trap_type_q;

    case (state_q)
      S_REQ: begin
        if (req_ack) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (resp_valid) begin
          state_d = S_WB;
          cnt_d   = '0;
          if (ld_q && (rd_q != 5'd0)) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = ld_val;
          end
        end else if (cnt_q == c_CNT_LAST) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          mem_trap_d  = 1'b1;
          trap_type_d = TRAP_ACCESS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      state_d = S_IDLE;
      if (opcode != 2'd3) begin
        wb_valid_d = (rd != 5'd0);
        wb_rd_d    = rd;
        wb_data_d  = addr[31:0];
      end else if (!dec_legal) begin
        mem_trap_d  = 1'b1;
        trap_type_d = TRAP_ILLEGAL;
      end else if (dec_misalign) begin
        mem_trap_d  = 1'b1;
        trap_type_d = TRAP_ALIGN;
      end else begin
        state_d     = S_REQ;
        req_addr_d  = addr[31:0];
        req_we_d    = !dec_load;
        req_size_d  = dec_size;
        req_wdata_d = dec_load ? 32'd0 : wdata_rep;
        ld_d        = dec_load;
        sgn_d       = dec_sgn;
        rd_d        = rd;
      end
    end
  end

  // State, request fields and pulse outputs; reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_addr_q  <= 32'd0;
      req_we_q    <= 1'b0;
      req_size_q  <= 2'd0;
      req_wdata_q <= 32'd0;
      ld_q        <= 1'b0;
      sgn_q       <= 1'b0;
      rd_q        <= 5'd0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'd0;
      mem_trap_q  <= 1'b0;
      trap_type_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_size_q  <= req_size_d;
      req_wdata_q <= req_wdata_d;
      ld_q        <= ld_d;
      sgn_q       <= sgn_d;
      rd_q        <= rd_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      mem_trap_q  <= mem_trap_d;
      trap_type_q <= trap_type_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage: table of single
//               transactions plus sequences for timeout, back-to-back issue
//               and reset in the middle of a transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exe_mem;
  logic [1:0]  opcode;
  logic [5:0]  op3;
  logic [4:0]  rd;
  logic [63:0] addr;
  logic [31:0] store_data;
  logic        mem_blocked;
  logic        req;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        req_ack;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_trap;
  logic [7:0]  trap_type;

  always #5 clk = ~clk;

  mem_stage #(
    .RESP_TIMEOUT(TO),
    .TRAP_ALIGN  (8'h07),
    .TRAP_ILLEGAL(8'h02),
    .TRAP_ACCESS (8'h29)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .exe_mem    (exe_mem),
    .opcode     (opcode),
    .op3        (op3),
    .rd         (rd),
    .addr       (addr),
    .store_data (store_data),
    .mem_blocked(mem_blocked),
    .req        (req),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .req_ack    (req_ack),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .mem_trap   (mem_trap),
    .trap_type  (trap_type)
  );

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_trap;
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [1:0]  opc;
    logic [5:0]  op3;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    bit          bus;
    bit          we;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          kind;   // 0 none, 1 writeback, 2 trap
    logic [31:0] val;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] opc, input logic [5:0] o3, input logic [4:0] r,
                              input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                              input bit bus, input bit we, input logic [1:0] sz,
                              input logic [31:0] wd, input int kind, input logic [31:0] val);
    vec_t v;
    v.opc = opc; v.op3 = o3; v.rd = r; v.addr = a; v.sdata = sd; v.rdata = rdat;
    v.bus = bus; v.we = we; v.size = sz; v.wdata = wd; v.kind = kind; v.val = val;
    return v;
  endfunction

  // Scoreboard monitor: every writeback or trap pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (wb_valid || mem_trap)) begin
      chk("wb_trap_exclusive", {31'd0, wb_valid & mem_trap}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_output", {30'd0, wb_valid, mem_trap}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("out_kind_is_trap", {31'd0, mem_trap}, {31'd0, mon_e.is_trap});
        if (mon_e.is_trap) begin
          chk("trap_type", {24'd0, trap_type}, mon_e.val);
        end else begin
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
          chk("wb_data", wb_data, mon_e.val);
        end
      end
    end
  end

  task automatic push_exp(input int kind, input logic [4:0] r, input logic [31:0] val);
    exp_t e;
    e.is_trap = (kind == 2);
    e.rd      = r;
    e.val     = val;
    if (kind != 0) sb.push_back(e);
  endtask

  task automatic drive_op(input logic [1:0] opc, input logic [5:0] o3, input logic [4:0] r,
                          input logic [31:0] a, input logic [31:0] sd);
    exe_mem    = 1'b1;
    opcode     = opc;
    op3        = o3;
    rd         = r;
    addr       = {$urandom(), a};
    store_data = sd;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive_op(v.opc, v.op3, v.rd, v.addr, v.sdata);
    push_exp(v.kind, v.rd, v.val);
    @(negedge clk);
    exe_mem = 1'b0;
    if (v.bus) begin
      chk("req", {31'd0, req}, 32'd1);
      chk("req_addr", req_addr, v.addr);
      chk("req_we", {31'd0, req_we}, {31'd0, v.we});
      chk("req_size", {30'd0, req_size}, {30'd0, v.size});
      if (v.we) chk("req_wdata", req_wdata, v.wdata);
      chk("blocked_req", {31'd0, mem_blocked}, 32'd1);
      repeat (2) begin
        @(negedge clk);
        chk("req_hold", {31'd0, req}, 32'd1);
        chk("req_addr_hold", req_addr, v.addr);
      end
      req_ack = 1'b1;
      @(negedge clk);
      req_ack = 1'b0;
      chk("req_drop", {31'd0, req}, 32'd0);
      chk("blocked_wait", {31'd0, mem_blocked}, 32'd1);
      repeat (2) @(negedge clk);
      resp_data  = v.rdata;
      resp_valid = 1'b1;
      @(negedge clk);
      resp_valid = 1'b0;
      resp_data  = 32'd0;
      chk("unblocked_wb", {31'd0, mem_blocked}, 32'd0);
    end else begin
      chk("no_req", {31'd0, req}, 32'd0);
      chk("no_block", {31'd0, mem_blocked}, 32'd0);
    end
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst_n = 1'b0; exe_mem = 1'b0; opcode = 2'd0; op3 = 6'd0; rd = 5'd0; addr = 64'd0;
    store_data = 32'd0; req_ack = 1'b0; resp_valid = 1'b0; resp_data = 32'd0;

    vt[0]  = mk(2'd2, 6'h00, 5'd5, 32'h0000_1234, 32'd0, 32'd0, 0, 0, 2'd0, 32'd0, 1, 32'h0000_1234);
    vt[1]  = mk(2'd0, 6'h00, 5'd0, 32'h0000_0055, 32'd0, 32'd0, 0, 0, 2'd0, 32'd0, 0, 32'd0);
    vt[2]  = mk(2'd3, 6'h09, 5'd3, 32'h0000_1001, 32'd0, 32'h11F2_3344, 1, 0, 2'd0, 32'd0, 1, 32'hFFFF_FFF2);
    vt[3]  = mk(2'd3, 6'h01, 5'd8, 32'h0000_1003, 32'd0, 32'h11F2_33F4, 1, 0, 2'd0, 32'd0, 1, 32'h0000_00F4);
    vt[4]  = mk(2'd3, 6'h02, 5'd9, 32'h0000_1002, 32'd0, 32'h1234_ABCD, 1, 0, 2'd1, 32'd0, 1, 32'h0000_ABCD);
    vt[5]  = mk(2'd3, 6'h0A, 5'd10, 32'h0000_1000, 32'd0, 32'h8001_0000, 1, 0, 2'd1, 32'd0, 1, 32'hFFFF_8001);
    vt[6]  = mk(2'd3, 6'h00, 5'd7, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, 1, 0, 2'd2, 32'd0, 1, 32'hDEAD_BEEF);
    vt[7]  = mk(2'd3, 6'h06, 5'd11, 32'h0000_2002, 32'hAAAA_BEEF, 32'd0, 1, 1, 2'd1, 32'hBEEF_BEEF, 0, 32'd0);
    vt[8]  = mk(2'd3, 6'h05, 5'd12, 32'h0000_2003, 32'h1234_56A5, 32'd0, 1, 1, 2'd0, 32'hA5A5_A5A5, 0, 32'd0);
    vt[9]  = mk(2'd3, 6'h04, 5'd13, 32'h0000_2000, 32'hCAFE_F00D, 32'd0, 1, 1, 2'd2, 32'hCAFE_F00D, 0, 32'd0);
    vt[10] = mk(2'd3, 6'h00, 5'd1, 32'h0000_3002, 32'd0, 32'd0, 0, 0, 2'd0, 32'd0, 2, 32'h0000_0007);
    vt[11] = mk(2'd3, 6'h02, 5'd1, 32'h0000_3001, 32'd0, 32'd0, 0, 0, 2'd0, 32'd0, 2, 32'h0000_0007);
    vt[12] = mk(2'd3, 6'h03, 5'd1, 32'h0000_3000, 32'd0, 32'd0, 0, 0, 2'd0, 32'd0, 2, 32'h0000_0002);
    vt[13] = mk(2'd3, 6'h07, 5'd1, 32'h0000_3000, 32'd0, 32'd0, 0, 0, 2'd0, 32'd0, 2, 32'h0000_0002);
    vt[14] = mk(2'd3, 6'h09, 5'd0, 32'h0000_0010, 32'd0, 32'h8000_0000, 1, 0, 2'd0, 32'd0, 0, 32'd0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_blocked", {31'd0, mem_blocked}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_mem_trap", {31'd0, mem_trap}, 32'd0);
    chk("rst_req_addr", req_addr, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_trap_type", {24'd0, trap_type}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_vec(vt[i]);

    // Bus timeout: trap exactly TO cycles after entering WAIT
    @(negedge clk);
    drive_op(2'd3, 6'h00, 5'd9, 32'h0000_4000, 32'd0);
    push_exp(2, 5'd0, 32'h0000_0029);
    @(negedge clk);
    exe_mem = 1'b0;
    chk("to_req", {31'd0, req}, 32'd1);
    req_ack = 1'b1;
    @(negedge clk);
    req_ack = 1'b0;
    chk("to_blocked", {31'd0, mem_blocked}, 32'd1);
    cyc = 0;
    while (!mem_trap && cyc < int'(TO) + 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("timeout_cycles", 32'(cyc), 32'(TO));
    chk("to_unblocked", {31'd0, mem_blocked}, 32'd0);
    repeat (2) @(negedge clk);
    chk("to_sb_drained", 32'(sb.size()), 32'd0);

    // Back-to-back: second load accepted in the WB cycle of the first
    @(negedge clk);
    drive_op(2'd3, 6'h01, 5'd4, 32'h0000_5002, 32'd0);
    push_exp(1, 5'd4, 32'h0000_00AA);
    @(negedge clk);
    exe_mem = 1'b0;
    req_ack = 1'b1;
    @(negedge clk);
    req_ack    = 1'b0;
    resp_data  = 32'h0011_AA33;
    resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    chk("b2b_wb_cycle", {31'd0, wb_valid}, 32'd1);
    chk("b2b_wb_unblocked", {31'd0, mem_blocked}, 32'd0);
    drive_op(2'd3, 6'h0A, 5'd6, 32'h0000_5000, 32'd0);
    push_exp(1, 5'd6, 32'hFFFF_9ABC);
    @(negedge clk);
    exe_mem = 1'b0;
    chk("b2b_req", {31'd0, req}, 32'd1);
    chk("b2b_req_addr", req_addr, 32'h0000_5000);
    chk("b2b_req_size", {30'd0, req_size}, 32'd1);
    req_ack = 1'b1;
    @(negedge clk);
    req_ack    = 1'b0;
    resp_data  = 32'h9ABC_1234;
    resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    resp_data  = 32'd0;
    repeat (2) @(negedge clk);
    chk("b2b_sb_drained", 32'(sb.size()), 32'd0);

    // Reset during WAIT, then a stale response
    @(negedge clk);
    drive_op(2'd3, 6'h00, 5'd2, 32'h0000_6000, 32'd0);
    @(negedge clk);
    exe_mem = 1'b0;
    req_ack = 1'b1;
    @(negedge clk);
    req_ack = 1'b0;
    chk("rw_blocked", {31'd0, mem_blocked}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_req", {31'd0, req}, 32'd0);
    chk("rw_unblocked", {31'd0, mem_blocked}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_data  = 32'h1234_5678;
    resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    chk("rw_no_wb", {31'd0, wb_valid}, 32'd0);
    repeat (2) @(negedge clk);
    chk("rw_idle", {31'd0, mem_blocked}, 32'd0);
    chk("final_sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory/writeback-feed stage directly downstream of the ALU in the SPARC V8 pipeline.
- Consumes the ALU's registered result as an effective address or pass-through value.
- For load/store instructions (opcode==3), runs a request/acknowledge/response transaction on the data bus and stalls the ALU via mem_blocked.
- Produces register-file writeback and memory trap indications.

Parameters:
- RESP_TIMEOUT, 256, max cycles waited in WAIT for resp_valid before a data_access_error trap (must be ≥2).
- TRAP_ALIGN, 8'h07, trap type for mem_address_not_aligned.
- TRAP_ILLEGAL, 8'h02, trap type for unsupported opcode==3 op3.
- TRAP_ACCESS, 8'h29, trap type for bus timeout.

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- exe_mem  in  1  ALU result valid
- opcode  in  2  instruction op field
- op3  in  6  instruction op3 field
- rd  in  5  destination register
- addr  in  64  ALU result; bits [31:0] used as address or pass-through value
- store_data  in  32  rd value for stores
- mem_blocked  out  1  stall to ALU
- req  out  1  bus request
- req_addr  out  32  bus byte address
- req_we  out  1  1=store
- req_size  out  2  0=byte, 1=half, 2=word
- req_wdata  out  32  lane-replicated store data
- req_ack  in  1  bus accepted request
- resp_valid  in  1  bus response (load data or store completion)
- resp_data  in  32  aligned big-endian word
- wb_valid  out  1  writeback pulse
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback value
- mem_trap  out  1  trap pulse
- trap_type  out  8  trap type, valid with mem_trap

Behaviour:
- Reset is asynchronous and active-low on rst_n; single clock clk. Reset forces state=IDLE and clears the timeout counter. All outputs 0 during/after reset: req, req_we, req_size, req_addr, req_wdata, wb_valid, wb_rd, wb_data, mem_trap, trap_type, mem_blocked.
- FSM states: IDLE, REQ, WAIT, WB.
- mem_blocked = (state==REQ || state==WAIT); decoded from the state register only.
- Accept condition: exe_mem && (state==IDLE || state==WB). Inputs are ignored otherwise; upstream holds them stable while mem_blocked=1.
- Non-memory op accepted (opcode!=3): next cycle wb_valid=1, wb_data=addr[31:0], wb_rd=rd. No bus activity; state stays IDLE.
- op3 decode when opcode==3: 00 LD, 01 LDUB, 02 LDUH, 04 ST, 05 STB, 06 STH, 09 LDSB, 0A LDSH.
- Any other op3 (including LDD 03): mem_trap=1, trap_type=TRAP_ILLEGAL for one cycle; no request, no writeback.
- Alignment check: half requires addr[0]==0; word requires addr[1:0]==0. On failure: mem_trap pulse with TRAP_ALIGN, no request, state IDLE.
- Valid access: state→REQ with req=1 and req_addr/req_we/req_size/req_wdata registered. All request fields held constant until req_ack is sampled high, then state→WAIT and req=0.
- Store data replication: STB {4{store_data[7:0]}}, STH {2{store_data[15:0]}}, ST store_data.
- WAIT: counter increments each cycle. On resp_valid, state→WB. If the counter reaches RESP_TIMEOUT first: mem_trap pulse with TRAP_ACCESS, state→IDLE, counter cleared.
- Load extraction in WB (big-endian): byte lane selected by addr[1:0], where 0 = resp_data[31:24]. Half lane selected by addr[1], where 0 = resp_data[31:16]. LDSB/LDSH sign-extend; LDUB/LDUH zero-extend.
- WB: one-cycle wb_valid for loads; stores produce no writeback. Next state is IDLE, or REQ/IDLE per a new accept in the same cycle.
- rd==0: wb_valid suppressed; the bus transaction still occurs.
- resp_valid outside WAIT and req_ack outside REQ are ignored.
- Reset mid-transaction: req drops immediately; a late resp_valid after reset is ignored.
- wb_valid and mem_trap are never asserted in the same cycle.

Test Plan:
- Reset then ADD result: exe_mem=1, opcode=2, addr=0x1234, rd=5 → next cycle wb_valid=1, wb_rd=5, wb_data=0x1234, mem_blocked never 1.
- LDSB addr=0x1001, rd=3, req_ack 2 cycles after req, resp_data=0x11F23344 → req_size=0, req_addr=0x1001, mem_blocked high through REQ/WAIT, wb_data=0xFFFFFFF2.
- STH addr=0x2002, store_data=0xAAAABEEF → req_we=1, req_size=1, req_wdata=0xBEEFBEEF; on resp_valid no wb_valid, return to IDLE.
- LD addr=0x3002 → mem_trap=1, trap_type=0x07, req never asserted; op3=0x03 → trap_type=0x02.
- LD with req_ack but no resp_valid → mem_trap with trap_type=0x29 exactly RESP_TIMEOUT cycles after entering WAIT; back-to-back LD issued in the WB cycle is accepted without a bubble.
- rst_n low during WAIT, then resp_valid → req=0, mem_blocked=0, no wb_valid.
